// File: rtl/rms_stream_engine.sv
// Streaming RMS engine: sums squares per frame, then runs a restoring divide and square root.
// Build macro RMS_ROUND_EN selects round-to-nearest with saturation (one extra cycle of latency).
module rms_stream_engine #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 9,
  parameter int FRAC_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_rdy,
  input  logic                     storage_reset,
  output logic [DATA_W+FRAC_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_rdy,
  output logic [1:0]               err_data,
  output logic                     err_valid
);
  localparam int ACC_W = 2*DATA_W + CNT_W;
  localparam int Q_W   = 2*(DATA_W + FRAC_W);
  localparam int R_W   = DATA_W + FRAC_W;
  localparam int N_W   = ACC_W + 2*FRAC_W;
  localparam int S_W   = R_W + 3;
  localparam int IT_W  = $clog2(Q_W + 2);
`ifdef RMS_ROUND_EN
  localparam int SQ_LAST = R_W;
`else
  localparam int SQ_LAST = R_W - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_RESET, S_IDLE, S_DIV, S_SQRT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [IT_W-1:0]       it_q, it_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      dr_q, dr_d;
  logic [Q_W-1:0]        sh_q, sh_d;
  logic [R_W-1:0]        rt_q, rt_d;
  logic [S_W-1:0]        sr_q, sr_d;
  logic [R_W-1:0]        out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            err_data_q, err_data_d;
  logic                  err_valid_q, err_valid_d;
  logic                  in_rdy_q, in_rdy_d;

  logic                  accept, ovf_now, div_bit, sq_bit;
  logic [2*DATA_W-1:0]   sq;
  logic [N_W-1:0]        dividend;
  logic [CNT_W:0]        div_trial;
  logic [S_W+1:0]        sq_cand, sq_sub;
  logic [R_W-1:0]        root_next, root_final;

  always_comb begin
    accept     = in_valid && in_rdy_q;
    ovf_now    = ovf_q || (cnt_q == CNT_MAX);
    sq         = {{DATA_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, in_data};
    dividend   = {acc_q, {(2*FRAC_W){1'b0}}};
    // Divider: remainder stays below count, so CNT_W+1 bits hold each trial.
    div_trial  = {dr_q, sh_q[Q_W-1]};
    div_bit    = div_trial >= {1'b0, cnt_q};
    // Square root: bring in two radicand bits, try subtracting 4r+1.
    sq_cand    = {sr_q, sh_q[Q_W-1:Q_W-2]};
    sq_sub     = (S_W+2)'({rt_q, 2'b01});
    sq_bit     = sq_cand >= sq_sub;
    root_next  = {rt_q[R_W-2:0], sq_bit};
`ifdef RMS_ROUND_EN
    root_final = ((sr_q > S_W'(rt_q)) && (rt_q != '1)) ? rt_q + 1'b1 : rt_q;
`else
    root_final = root_next;
`endif

    state_d     = state_q;
    it_d        = it_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    dr_d        = dr_q;
    sh_d        = sh_q;
    rt_d        = rt_q;
    sr_d        = sr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_data_d  = 2'b00;
    err_valid_d = 1'b0;

    if (storage_reset) begin
      state_d     = S_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      // A result handed off on this same edge counts as delivered, not aborted.
      if ((state_q == S_DIV) || (state_q == S_SQRT) ||
          ((state_q == S_OUT) && !(out_valid_q && out_rdy))) begin
        err_valid_d = 1'b1;
        err_data_d  = 2'b10;
      end
    end else begin
      unique case (state_q)
        S_RESET: state_d = S_IDLE;
        S_IDLE: begin
          if (accept) begin
            if (ovf_now) begin
              if (in_last) begin
                err_valid_d = 1'b1;
                err_data_d  = 2'b01;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              acc_d = acc_q + ACC_W'(sq);
              cnt_d = cnt_q + 1'b1;
              if (in_last) begin
                state_d = S_DIV;
                it_d    = '0;
              end
            end
          end
        end
        S_DIV: begin
          if (it_q == '0) begin
            dr_d = dividend[N_W-1:Q_W];
            sh_d = dividend[Q_W-1:0];
          end else begin
            dr_d = CNT_W'(div_bit ? div_trial - {1'b0, cnt_q} : div_trial);
            sh_d = {sh_q[Q_W-2:0], div_bit};
          end
          if (it_q == IT_W'(Q_W)) begin
            state_d = S_SQRT;
            it_d    = '0;
            rt_d    = '0;
            sr_d    = '0;
          end else begin
            it_d = it_q + 1'b1;
          end
        end
        S_SQRT: begin
          if (it_q < IT_W'(R_W)) begin
            sr_d = S_W'(sq_bit ? sq_cand - sq_sub : sq_cand);
            rt_d = root_next;
            sh_d = {sh_q[Q_W-3:0], 2'b00};
          end
          if (it_q == IT_W'(SQ_LAST)) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_data_d  = root_final;
          end else begin
            it_d = it_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_rdy) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    in_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      it_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      dr_q        <= '0;
      sh_q        <= '0;
      rt_q        <= '0;
      sr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_data_q  <= 2'b00;
      err_valid_q <= 1'b0;
      in_rdy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      it_q        <= it_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      dr_q        <= dr_d;
      sh_q        <= sh_d;
      rt_q        <= rt_d;
      sr_q        <= sr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_data_q  <= err_data_d;
      err_valid_q <= err_valid_d;
      in_rdy_q    <= in_rdy_d;
    end
  end

  assign in_rdy    = in_rdy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_data  = err_data_q;
  assign err_valid = err_valid_q;
endmodule

// File: tb/tb_rms_stream_engine.sv
// Directed bench for rms_stream_engine at default widths; expectations follow RMS_ROUND_EN if defined.
module tb_rms_stream_engine;
`ifdef RMS_ROUND_EN
  localparam int LAT = 38;
  localparam logic [11:0] EXP34 = 12'h039;
`else
  localparam int LAT = 37;
  localparam logic [11:0] EXP34 = 12'h038;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, storage_reset, out_rdy;
  logic [7:0]  in_data;
  logic        in_rdy, out_valid, err_valid;
  logic [11:0] out_data;
  logic [1:0]  err_data;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  rms_stream_engine #(.DATA_W(8), .CNT_W(9), .FRAC_W(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_rdy(in_rdy), .storage_reset(storage_reset), .out_data(out_data),
    .out_valid(out_valid), .out_rdy(out_rdy), .err_data(err_data), .err_valid(err_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_data = d; in_valid = 1'b1; in_last = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 100);
  endtask

  task automatic test_reset();
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== 12'h000) begin tests_failed++; $display("FAIL reset_out_data: got %h want 000", out_data); end
    tests_run++; if (err_valid !== 1'b0 || err_data !== 2'b00) begin tests_failed++; $display("FAIL reset_err: got %b/%b want 0/00", err_valid, err_data); end
    rst = 1'b0;
    #1;
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_rdy: got %b want 0", in_rdy); end
    step();
    tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy_rise: got %b want 1", in_rdy); end
  endtask

  task automatic test_four_tens();
    int n;
    for (int i = 0; i < 4; i++) send(8'd10, i == 3);
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL tens_rdy_fall: got %b want 0", in_rdy); end
    wait_out(n);
    tests_run++; if (n != LAT) begin tests_failed++; $display("FAIL tens_latency: got %0d want %0d", n, LAT); end
    tests_run++; if (out_data !== 12'h0A0) begin tests_failed++; $display("FAIL tens_data: got %h want 0a0", out_data); end
    tests_run++; if (err_valid !== 1'b0) begin tests_failed++; $display("FAIL tens_err: got %b want 0", err_valid); end
    step();
    tests_run++; if (out_valid !== 1'b0 || in_rdy !== 1'b1) begin tests_failed++; $display("FAIL tens_handshake: got valid=%b rdy=%b want 0/1", out_valid, in_rdy); end
  endtask

  task automatic test_frame_3_4();
    int n;
    send(8'd3, 1'b0);
    send(8'd4, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== EXP34) begin tests_failed++; $display("FAIL frame34_data: got %h want %h", out_data, EXP34); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 2; k++) begin
      send(8'd255, 1'b1);
      wait_out(n);
      tests_run++; if (n != LAT) begin tests_failed++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, n, LAT); end
      tests_run++; if (out_data !== 12'hFF0) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h want ff0", k, out_data); end
      step();
      tests_run++; if (out_valid !== 1'b0 || in_rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_handshake[%0d]: got valid=%b rdy=%b want 0/1", k, out_valid, in_rdy); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_rdy = 1'b0;
    send(8'd255, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== 12'hFF0) begin tests_failed++; $display("FAIL bp_data: got %h want ff0", out_data); end
    for (int c = 0; c < 20; c++) begin
      step();
      tests_run++;
      if (out_data !== 12'hFF0 || out_valid !== 1'b1 || in_rdy !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got data=%h valid=%b rdy=%b want ff0/1/0", c, out_data, out_valid, in_rdy);
      end
    end
    out_rdy = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b0 || in_rdy !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got valid=%b rdy=%b want 0/1", out_valid, in_rdy); end
  endtask

  task automatic test_overflow();
    int n;
    bit seen;
    for (int i = 0; i < 512; i++) send(8'd1, i == 511);
    tests_run++; if (err_valid !== 1'b1 || err_data !== 2'b01) begin tests_failed++; $display("FAIL ovf_err: got %b/%b want 1/01", err_valid, err_data); end
    tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL ovf_rdy: got %b want 1", in_rdy); end
    step();
    tests_run++; if (err_valid !== 1'b0 || err_data !== 2'b00) begin tests_failed++; $display("FAIL ovf_err_pulse: got %b/%b want 0/00", err_valid, err_data); end
    seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_out: got out_valid seen=%b want 0", seen); end
    send(8'd2, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== 12'h020) begin tests_failed++; $display("FAIL ovf_next_frame: got %h want 020", out_data); end
    step();
  endtask

  task automatic test_storage_reset();
    int n;
    bit seen;
    send(8'd255, 1'b1);
    repeat (29) step();
    storage_reset = 1'b1;
    step();
    storage_reset = 1'b0;
    tests_run++; if (err_valid !== 1'b1 || err_data !== 2'b10) begin tests_failed++; $display("FAIL abort_err: got %b/%b want 1/10", err_valid, err_data); end
    tests_run++; if (in_rdy !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_state: got rdy=%b valid=%b want 1/0", in_rdy, out_valid); end
    step();
    tests_run++; if (err_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_pulse: got %b want 0", err_valid); end
    seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_no_out: got out_valid seen=%b want 0", seen); end
    send(8'd5, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== 12'h050 || n != LAT) begin tests_failed++; $display("FAIL abort_next_frame: got %h after %0d want 050 after %0d", out_data, n, LAT); end
    step();
    // Clear in IDLE: no error, and the partial frame is discarded.
    send(8'd7, 1'b0);
    storage_reset = 1'b1;
    step();
    storage_reset = 1'b0;
    tests_run++; if (err_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_clear_err: got %b want 0", err_valid); end
    send(8'd2, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== 12'h020) begin tests_failed++; $display("FAIL idle_clear_frame: got %h want 020", out_data); end
    step();
  endtask

  task automatic test_rst_mid_div();
    int n;
    send(8'd5, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    #1;
    tests_run++; if (in_rdy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_ctrl: got rdy=%b valid=%b want 0/0", in_rdy, out_valid); end
    tests_run++; if (out_data !== 12'h000) begin tests_failed++; $display("FAIL rst_data: got %h want 000", out_data); end
    tests_run++; if (err_valid !== 1'b0 || err_data !== 2'b00) begin tests_failed++; $display("FAIL rst_err: got %b/%b want 0/00", err_valid, err_data); end
    step();
    rst = 1'b0;
    #1;
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_rdy: got %b want 0", in_rdy); end
    step();
    tests_run++; if (in_rdy !== 1'b1 || err_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rdy_rise: got rdy=%b err=%b want 1/0", in_rdy, err_valid); end
    send(8'd10, 1'b1);
    wait_out(n);
    tests_run++; if (out_data !== 12'h0A0) begin tests_failed++; $display("FAIL rst_next_frame: got %h want 0a0", out_data); end
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
    storage_reset = 1'b0; out_rdy = 1'b1;
    repeat (2) step();
    test_reset();
    test_four_tens();
    test_frame_3_4();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_storage_reset();
    test_rst_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rms_stream_engine.md
# rms_stream_engine

Parametrised streaming RMS engine: accumulates squares of an unsigned sample frame, divides by the sample count and takes an integer square root. It returns a fixed-point RMS value, or an error code, per frame. Successor to the single-width RMS calculator in the sample-processing path. It adds generic widths, framing via `in_last`, output backpressure, live error reporting, and a sequential divider and square root that replace the combinational divide.

## Interface
- `DATA_W`, default 8: sample width, unsigned.
- `CNT_W`, default 9: count width; a frame holds at most 2^CNT_W−1 samples.
- `FRAC_W`, default 4: fractional bits of the result.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_data` in DATA_W: sample.
- `in_valid` in 1: sample present.
- `in_last` in 1: marks the final sample of a frame; qualified by `in_valid && in_rdy`.
- `in_rdy` out 1: engine accepts samples.
- `storage_reset` in 1: synchronous abort/clear, highest priority after `rst`.
- `out_data` out DATA_W+FRAC_W: RMS in unsigned Q(DATA_W).(FRAC_W).
- `out_valid` out 1: result valid; held until accepted.
- `out_rdy` in 1: downstream accepts the result.
- `err_data` out 2: error code. 01 = count overflow, 10 = abort.
- `err_valid` out 1: one-cycle error pulse.

## Operation
- Derived widths:
  - ACC_W = 2·DATA_W+CNT_W
  - Q_W = 2·(DATA_W+FRAC_W)
  - R_W = DATA_W+FRAC_W
- States: RESET, IDLE, DIV, SQRT, OUT.
  - RESET→IDLE: unconditional on the first edge after `rst` deasserts.
  - IDLE→DIV: on acceptance of a sample with `in_last` when no overflow is flagged.
  - IDLE→IDLE: on acceptance of an `in_last` sample when overflow is flagged. Pulse err 01; clear accumulator, count and flag.
  - DIV→SQRT: after Q_W iterations.
  - SQRT→OUT: after R_W iterations.
  - OUT→IDLE: when `out_valid && out_rdy`.
- IDLE, per accepted sample:
  - acc += in_data², computed at full ACC_W, no truncation.
  - count += 1.
  - If count == 2^CNT_W−1 before the add, set the overflow flag. The sample is discarded and count and acc hold. Later samples of the frame are also discarded until `in_last`.
- DIV: restoring divider, one quotient bit per cycle.
  - q = floor((acc << 2·FRAC_W) / count).
  - q is truncated to Q_W bits; this is lossless for count ≥ 1.
- SQRT: restoring digit-by-digit, one root bit per cycle. r = floor(sqrt(q)), R_W bits.
- OUT:
  - `out_data` = r, held stable while `out_valid && !out_rdy`.
  - Accumulator and count clear on the handshake.
- `in_rdy` = 1 only in IDLE. Samples offered outside IDLE are ignored.
- `storage_reset` takes effect in any state:
  - Next state is IDLE; acc, count, overflow flag and `out_valid` clear.
  - If asserted in DIV, SQRT or OUT, pulse err 10 on the following cycle. In IDLE, no error is reported.
- A simultaneous `storage_reset` and accepted sample drops the sample.
- A simultaneous `storage_reset` and output handshake takes no error; the result counts as delivered.

## Timing
- Reset values:
  - `in_rdy` = 0, `out_valid` = 0, `out_data` = 0, `err_valid` = 0, `err_data` = 00.
  - acc = 0, count = 0.
- `in_rdy` rises on the first clk edge after `rst` deasserts.
- Let the edge accepting the `in_last` sample be edge 0:
  - `in_rdy` falls after edge 0.
  - `out_valid` rises after edge Q_W+R_W+1. With defaults that is 24+12+1 = 37 cycles.
- `in_rdy` returns one cycle after the output handshake edge.
- Error pulses last exactly one cycle and are registered. `err_data` returns to 00 with `err_valid`.
- `rst` mid-operation returns to RESET immediately. No error pulse is generated.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `RMS_ROUND_EN` defined: round-to-nearest.
  - After SQRT, with remainder rem = q − r², r becomes r+1 when rem > r.
  - The result saturates at all-ones.
  - Adds one cycle: `out_valid` rises after edge Q_W+R_W+2.
- Undefined: floor result, latency as stated in Timing.

## Test plan
- Four samples of 10 with `in_last` on the 4th → `out_data` = 0x0A0 (10.0) after 37 cycles, `err_valid` = 0.
- Frame {3,4} → 0x038 without `RMS_ROUND_EN`, 0x039 with it (q = 3200, sqrt = 56.57).
- Single sample 255 with `in_last` → 0xFF0. Run both back-to-back and with `out_rdy` held low 20 cycles: `out_data` stable, `in_rdy` = 0 until the handshake.
- 512 samples of 1, last one with `in_last` (CNT_W = 9):
  - no `out_valid`;
  - err 01 pulse one cycle after the last sample;
  - a following frame {2} yields 0x020.
- `storage_reset` pulsed at edge 30 (in SQRT) → err 10 pulse, `in_rdy` = 1 next cycle, no `out_valid`. A new frame {5} then yields 0x050.
- `rst` asserted mid-DIV → all outputs at reset values immediately. `in_rdy` rises one edge after release.
